mdu_scheduler: RTL and testbench
================================

// Module: mdu_scheduler
// PURPOSE
//   Multi-cycle mult/div sequencer and HI/LO register owner for the 5-stage pipeline.
//   Accepts one mult/multu/div/divu from EX and counts out its latency, then commits the result to HI/LO.
//   Raises a stall toward the hazard logic while an HI/LO-using instruction sits in ID.
//   Also serves mthi/mtlo writes and mfhi/mflo reads (EX stage).
// PARAMETERS
//   MULT_CYCLES  5   busy cycles for mult/multu (>=1)
//   DIV_CYCLES   10  busy cycles for div/divu (>=1)
// PORTS
//   clk       in   1   rising-edge clock
//   reset     in   1   asynchronous, active-high; clears all state
//   start     in   1   EX holds mult/multu/div/divu this cycle
//   op        in   2   00 mult, 01 multu, 10 div, 11 divu (valid with start)
//   A         in   32  rs operand (forwarded, EX)
//   B         in   32  rt operand (forwarded, EX)
//   mthi      in   1   EX holds mthi; HI <= A
//   mtlo      in   1   EX holds mtlo; LO <= A
//   md_use_ID in   1   ID holds any of mult/multu/div/divu/mfhi/mflo/mthi/mtlo
//   HI        out  32  architectural HI
//   LO        out  32  architectural LO
//   busy      out  1   operation in flight
//   Stall_MDU out  1   = md_use_ID & (start | busy); ORed into pipeline Stall
// BEHAVIOUR
//   Reset: state=IDLE, HI=0, LO=0, busy=0, counter=0. Stall_MDU follows its equation (0 if md_use_ID=0).
//   States: IDLE, BUSY.
//   IDLE & start at cycle t:
//     - latch op, A, B; counter <= N-1 (N = MULT_CYCLES or DIV_CYCLES); -> BUSY.
//     - busy=1 in cycles t+1..t+N.
//     - HI/LO updated at the edge ending cycle t+N, visible from cycle t+N+1.
//     - busy=0 from cycle t+N+1, state IDLE.
//   BUSY: counter decrements each cycle; at 0 commit and -> IDLE.
//   Arithmetic:
//     - mult: {HI,LO} = $signed(A)*$signed(B), 64-bit.
//     - multu: unsigned 64-bit product.
//     - div: LO = quotient, HI = remainder, signed, truncate toward zero; remainder takes the dividend's sign.
//       0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
//     - divu: unsigned quotient/remainder.
//     - B == 0 for div/divu: HI/LO left unchanged at commit.
//   Result is computed from latched operands. A/B changing after start has no effect.
//   mthi/mtlo:
//     - Take effect at the next edge when state is IDLE and start = 0.
//     - mthi and mtlo in the same cycle: both write.
//     - While BUSY, or with start asserted: ignored (start has priority).
//   start while BUSY: ignored, no restart (Stall_MDU prevents this legally).
//   HI/LO outputs are registers; a read in the commit cycle t+N returns the old values.
//   Reset mid-operation: abort immediately; HI = LO = 0, IDLE. No commit.
//   Back-to-back: start in cycle t+N+1 (first IDLE cycle) is accepted.
// CONFIGURATION
//   MDU_DIV0_FAST_EN defined:
//     - div/divu with B == 0 at start does not enter BUSY; busy stays 0.
//     - HI/LO unchanged; zero stall cycles.
//   Not defined: div-by-zero occupies the full DIV_CYCLES with busy=1, then leaves HI/LO unchanged.
// TESTING
//   1. reset=1 asynchronously mid-cycle -> HI=LO=0, busy=0 before the next clk edge.
//   2. start, op=00, A=0xFFFFFFFE (-2), B=3 at t -> busy t+1..t+5; HI=0xFFFFFFFF, LO=0xFFFFFFFA at t+6.
//   3. start, op=10, A=0xFFFFFFF9 (-7), B=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//      Same with op=11 -> LO=0x7FFFFFFC, HI=1.
//   4. md_use_ID=1 held during scenario 2 -> Stall_MDU=1 in cycles t..t+5 and 0 at t+6.
//      mthi A=0x1234 at t+3 is ignored; mthi at t+6 -> HI=0x1234 at t+7.
//   5. div with B=0, HI=0xAA, LO=0xBB:
//      - macro off: busy for 10 cycles, HI/LO unchanged.
//      - MDU_DIV0_FAST_EN: busy never 1, HI/LO unchanged.
//   6. multu A=B=0xFFFFFFFF, reset pulse at t+2 -> HI=LO=0, busy=0, no later commit.
//      Then multu re-issued -> HI=0xFFFFFFFE, LO=0x00000001.

Source files
------------

// File: rtl/mdu_scheduler.sv
// mdu_scheduler
//   Multi-cycle mult/div sequencer and owner of the architectural HI/LO pair.
//   One mult/multu/div/divu is accepted from EX while IDLE. Operands are latched,
//   the operation's latency is counted out, and the result is committed to HI/LO
//   on the edge that ends the last busy cycle. mthi/mtlo write HI/LO from A when
//   the unit is idle and no operation is starting.
//
//   Optional feature (define MDU_DIV0_FAST_EN): a div/divu whose divisor is zero
//   at start is dropped immediately instead of occupying DIV_CYCLES.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset, clears all state
//   start      EX holds mult/multu/div/divu this cycle
//   op         00 mult, 01 multu, 10 div, 11 divu (valid with start)
//   A, B       forwarded rs / rt operands from EX
//   mthi/mtlo  EX holds mthi / mtlo (HI <= A / LO <= A)
//   md_use_ID  ID holds an instruction that uses the mult/div unit or HI/LO
//   HI, LO     architectural HI / LO registers
//   busy       an operation is in flight
//   Stall_MDU  md_use_ID & (start | busy)
module mdu_scheduler #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic        md_use_ID,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy,
  output logic        Stall_MDU
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_nxt;
  logic [1:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] cnt;

  logic        accept;
  logic        done;
  logic        div_by_zero;

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, q_mag, r_mag;
  logic [31:0] q_s, r_s, q_u, r_u;
  logic [63:0] result;

`ifdef MDU_DIV0_FAST_EN
  assign accept = (state == IDLE) && start && !(op[1] && (B == '0));
`else
  assign accept = (state == IDLE) && start;
`endif

  assign done        = (state == BUSY) && (cnt == '0);
  assign div_by_zero = op_q[1] && (b_q == '0);
  assign busy        = (state == BUSY);
  assign Stall_MDU   = md_use_ID & (start | busy);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Signed divide is done on magnitudes and re-signed afterwards. This keeps
  // 0x80000000 / -1 well defined (quotient wraps to 0x80000000, remainder 0)
  // and makes the remainder follow the dividend's sign.
  always_comb begin
    prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u = {32'h0, a_q} * {32'h0, b_q};
    a_mag  = a_q[31] ? -a_q : a_q;
    b_mag  = b_q[31] ? -b_q : b_q;
    q_mag  = '0;
    r_mag  = '0;
    q_u    = '0;
    r_u    = '0;
    if (b_q != '0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
      q_u   = a_q / b_q;
      r_u   = a_q % b_q;
    end
    q_s = (a_q[31] ^ b_q[31]) ? -q_mag : q_mag;
    r_s = a_q[31] ? -r_mag : r_mag;
    case (op_q)
      2'b00:   result = prod_s;
      2'b01:   result = prod_u;
      2'b10:   result = {r_s, q_s};
      default: result = {r_u, q_u};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      cnt  <= '0;
      HI   <= '0;
      LO   <= '0;
    end else begin
      if (accept) begin
        op_q <= op;
        a_q  <= A;
        b_q  <= B;
        cnt  <= op[1] ? DIV_CYCLES - 32'd1 : MULT_CYCLES - 32'd1;
      end else if (state == IDLE && !start) begin
        if (mthi) HI <= A;
        if (mtlo) LO <= A;
      end
      if (state == BUSY && cnt != '0) cnt <= cnt - 32'd1;
      if (done && !div_by_zero) begin
        HI <= result[63:32];
        LO <= result[31:0];
      end
    end
  end

endmodule

// File: tb/tb_mdu_scheduler.sv
// Directed bench for mdu_scheduler with an expected-result queue per operation.
module tb_mdu_scheduler;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = '0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic        md_use_ID = 1'b0;
  logic [31:0] HI, LO;
  logic        busy, Stall_MDU;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [63:0] exp_q[$];

  mdu_scheduler #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .mthi(mthi), .mtlo(mtlo), .md_use_ID(md_use_ID),
    .HI(HI), .LO(LO), .busy(busy), .Stall_MDU(Stall_MDU)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed no end of test, expected completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] cur);
    longint          sa, sb;
    longint unsigned ua, ub;
    longint          p, q, r;
    longint unsigned up, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (o)
      2'b00: begin p = sa * sb; return p; end
      2'b01: begin up = ua * ub; return up; end
      2'b10: begin
        if (b == 32'h0) return cur;
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'h0) return cur;
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  // Issue one operation in the current cycle t and follow it to t+N+1.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int unsigned inj_mthi, input int unsigned inj_start);
    int unsigned n;
    logic [63:0] e;
    n = o[1] ? DC : MC;
`ifdef MDU_DIV0_FAST_EN
    if (o[1] && b == 32'h0) n = 0;
`endif
    exp_q.push_back(model(o, a, b, {m_hi, m_lo}));
    start = 1'b1; op = o; A = a; B = b;
    #1;
    check("stall_start", Stall_MDU, md_use_ID);
    cyc();
    start = 1'b0; A = $urandom; B = $urandom; op = 2'($urandom);
    for (int unsigned i = 1; i <= n; i++) begin
      check("busy_on", busy, 1'b1);
      check("hilo_hold", {HI, LO}, {m_hi, m_lo});
      check("stall_busy", Stall_MDU, md_use_ID);
      if (i == inj_mthi) begin mthi = 1'b1; A = 32'h1234; end
      if (i == inj_start) begin start = 1'b1; op = 2'($urandom); end
      cyc();
      mthi = 1'b0; start = 1'b0;
    end
    check("busy_off", busy, 1'b0);
    check("stall_done", Stall_MDU, 1'b0);
    if (exp_q.size() == 0) begin
      check("queue_empty", 64'(exp_q.size()), 64'd1);
    end else begin
      e = exp_q.pop_front();
      check("result", {HI, LO}, e);
      {m_hi, m_lo} = e;
    end
  endtask

  task automatic mt(input logic wh, input logic wl, input logic [31:0] v);
    mthi = wh; mtlo = wl; A = v;
    cyc();
    mthi = 1'b0; mtlo = 1'b0;
    if (wh) m_hi = v;
    if (wl) m_lo = v;
    check("mt_hilo", {HI, LO}, {m_hi, m_lo});
  endtask

  initial begin
    md_use_ID = 1'b1;
    cyc(); cyc();
    check("rst_hilo", {HI, LO}, 64'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_stall", Stall_MDU, 1'b0);
    reset = 1'b0;
    md_use_ID = 1'b0;
    cyc();

    // mthi/mtlo then asynchronous reset mid-cycle
    mt(1'b1, 1'b0, 32'h55);
    mt(1'b0, 1'b1, 32'h66);
    #3 reset = 1'b1;
    #1;
    check("async_rst_hilo", {HI, LO}, 64'h0);
    check("async_rst_busy", busy, 1'b0);
    m_hi = '0; m_lo = '0;
    cyc();
    reset = 1'b0;
    cyc();

    // mult -2*3 with ID stall, mthi ignored at t+3, accepted at t+6
    md_use_ID = 1'b1;
    run_op(2'b00, 32'hFFFFFFFE, 32'd3, 3, 0);
    check("mult_const", {HI, LO}, 64'hFFFFFFFF_FFFFFFFA);
    mt(1'b1, 1'b0, 32'h1234);
    check("mthi_after", HI, 32'h1234);
    md_use_ID = 1'b0;

    // divides, back-to-back
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, 0, 0);
    check("div_const", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
    run_op(2'b11, 32'hFFFFFFF9, 32'd2, 0, 0);
    check("divu_const", {HI, LO}, 64'h00000001_7FFFFFFC);
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 0, 0);
    check("div_ovf", {HI, LO}, 64'h00000000_80000000);
    run_op(2'b10, 32'd7, 32'hFFFFFFFE, 0, 4);
    check("div_rem_sign", {HI, LO}, 64'h00000001_FFFFFFFD);

    // mthi/mtlo together, then mthi alongside start is ignored
    mt(1'b1, 1'b1, 32'hCAFE);
    mt(1'b1, 1'b0, 32'hAA);
    mt(1'b0, 1'b1, 32'hBB);
    mthi = 1'b1;
    run_op(2'b01, 32'd2, 32'd3, 0, 0);
    mthi = 1'b0;
    mt(1'b1, 1'b0, 32'hAA);
    mt(1'b0, 1'b1, 32'hBB);

    // divide by zero leaves HI/LO
    run_op(2'b10, 32'd100, 32'd0, 0, 0);
    check("div0_hilo", {HI, LO}, 64'h000000AA_000000BB);

    // reset mid-operation aborts without commit
    start = 1'b1; op = 2'b01; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF;
    cyc();
    start = 1'b0;
    check("abort_busy", busy, 1'b1);
    cyc();
    reset = 1'b1;
    #1;
    check("abort_hilo", {HI, LO}, 64'h0);
    check("abort_busy0", busy, 1'b0);
    m_hi = '0; m_lo = '0;
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("abort_no_commit", {busy, HI, LO}, 65'h0);
      cyc();
    end
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    check("multu_max", {HI, LO}, 64'hFFFFFFFE_00000001);

    // random back-to-back operations
    for (int i = 0; i < 6; i++) begin
      md_use_ID = 1'($urandom);
      run_op(2'($urandom), $urandom, (i == 3) ? 32'h0 : $urandom, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
